// File: rtl/lsu_ctrl.sv
// Load/store sequencer between decode and a word-wide byte-enabled data bus.
// Splits misaligned half/word accesses into two beats and extends load data.
module lsu_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_mem_wren,
  input  logic [1:0]  i_data_type,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic        o_ld_vld,
  output logic [31:0] o_ld_data,
  output logic        o_err,
  output logic        o_bus_vld,
  input  logic        i_bus_rdy,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvld,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_RESP0, S_REQ1, S_RESP1, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] st_q, st_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        load_q, load_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_vld_q, ld_vld_d;
  logic        err_q, err_d;
  logic        bus_vld_q, bus_vld_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b1111;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b0001;
    endcase
  endfunction

  logic        req_ok, req_bad, split, accept;
  logic        issue1, clr;
  logic [4:0]  sh_in, sh_q;
  logic [3:0]  be0, be1;
  logic [31:0] wd0, wd1, addr1;
  logic [31:0] r0, r1, raw, ld_ext;

  assign req_bad = (i_mem_wren == 2'b11) ||
                   (i_mem_wren != 2'b00 && i_data_type == 2'b11);
  assign req_ok  = (i_mem_wren == 2'b10 || i_mem_wren == 2'b01) &&
                   i_data_type != 2'b11;

  assign sh_in = {i_addr[1:0], 3'b000};
  assign sh_q  = {addr_q[1:0], 3'b000};
  assign be0   = size_mask(i_data_type) << i_addr[1:0];
  assign wd0   = i_st_data << sh_in;

  // Lanes that spill past the word boundary form the second beat.
  assign be1   = size_mask(size_q) >> (3'd4 - {1'b0, addr_q[1:0]});
  assign wd1   = st_q >> (6'd32 - {1'b0, sh_q});
  assign split = |be1;
  assign addr1 = {addr_q[31:2], 2'b00} + 32'd4;

  assign r0  = (state_q == S_RESP0) ? i_bus_rdata : rdata0_q;
  assign r1  = (state_q == S_RESP1) ? i_bus_rdata : 32'd0;
  assign raw = (r0 >> sh_q) | (r1 << (6'd32 - {1'b0, sh_q}));

  always_comb begin
    ld_ext = raw;
    case (size_q)
      2'b01:   ld_ext = {{16{~uns_q & raw[15]}}, raw[15:0]};
      2'b10:   ld_ext = {{24{~uns_q & raw[7]}}, raw[7:0]};
      default: ld_ext = raw;
    endcase
  end

  assign accept = bus_vld_q & i_bus_rdy;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    st_d        = st_q;
    size_d      = size_q;
    uns_d       = uns_q;
    load_d      = load_q;
    rdata0_d    = rdata0_q;
    ld_data_d   = ld_data_q;
    ld_vld_d    = 1'b0;
    err_d       = 1'b0;
    bus_vld_d   = bus_vld_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    issue1      = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_bad) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          ld_data_d = 32'd0;
        end else if (req_ok) begin
          state_d     = S_REQ0;
          addr_d      = i_addr;
          st_d        = i_st_data;
          size_d      = i_data_type;
          uns_d       = i_unsigned;
          load_d      = i_mem_wren[1];
          bus_vld_d   = 1'b1;
          bus_we_d    = i_mem_wren[0];
          bus_addr_d  = {i_addr[31:2], 2'b00};
          bus_be_d    = be0;
          bus_wdata_d = wd0;
        end
      end
      S_REQ0, S_REQ1: begin
        if (accept) begin
          if (load_q) begin
            clr     = 1'b1;
            state_d = (state_q == S_REQ0) ? S_RESP0 : S_RESP1;
          end else if (state_q == S_REQ0 && split) begin
            issue1  = 1'b1;
            state_d = S_REQ1;
          end else begin
            clr     = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RESP0: begin
        if (i_bus_rvld) begin
          rdata0_d = i_bus_rdata;
          if (split) begin
            issue1  = 1'b1;
            state_d = S_REQ1;
          end else begin
            state_d   = S_DONE;
            ld_vld_d  = 1'b1;
            ld_data_d = ld_ext;
          end
        end
      end
      S_RESP1: begin
        if (i_bus_rvld) begin
          state_d   = S_DONE;
          ld_vld_d  = 1'b1;
          ld_data_d = ld_ext;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      bus_vld_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_addr_d  = 32'd0;
      bus_be_d    = 4'd0;
      bus_wdata_d = 32'd0;
    end
    if (issue1) begin
      bus_vld_d   = 1'b1;
      bus_we_d    = ~load_q;
      bus_addr_d  = addr1;
      bus_be_d    = be1;
      bus_wdata_d = wd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      st_q        <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      rdata0_q    <= '0;
      ld_data_q   <= '0;
      ld_vld_q    <= 1'b0;
      err_q       <= 1'b0;
      bus_vld_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      st_q        <= st_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      load_q      <= load_d;
      rdata0_q    <= rdata0_d;
      ld_data_q   <= ld_data_d;
      ld_vld_q    <= ld_vld_d;
      err_q       <= err_d;
      bus_vld_q   <= bus_vld_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign o_stall     = (state_q == S_IDLE && i_mem_wren != 2'b00) ||
                       (state_q != S_IDLE && state_q != S_DONE);
  assign o_ld_vld    = ld_vld_q;
  assign o_ld_data   = ld_data_q;
  assign o_err       = err_q;
  assign o_bus_vld   = bus_vld_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_be    = bus_be_q;
  assign o_bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table plus backpressure and
// mid-transaction reset sequences.
module tb_lsu_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_mem_wren;
  logic [1:0]  i_data_type;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_stall;
  logic        o_ld_vld;
  logic [31:0] o_ld_data;
  logic        o_err;
  logic        o_bus_vld;
  logic        i_bus_rdy;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rvld;
  logic [31:0] i_bus_rdata;

  lsu_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_mem_wren  (i_mem_wren),
    .i_data_type (i_data_type),
    .i_unsigned  (i_unsigned),
    .i_addr      (i_addr),
    .i_st_data   (i_st_data),
    .o_stall     (o_stall),
    .o_ld_vld    (o_ld_vld),
    .o_ld_data   (o_ld_data),
    .o_err       (o_err),
    .o_bus_vld   (o_bus_vld),
    .i_bus_rdy   (i_bus_rdy),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_be    (o_bus_be),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_rvld  (i_bus_rvld),
    .i_bus_rdata (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  wren;
    logic [1:0]  dt;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] r0;
    logic [31:0] r1;
    int          stall;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] w1;
    logic [31:0] ld;
    logic        err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input int tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL t%0d %s: got %h want %h", tag, name, act, exp);
    end
  endtask

  task automatic run_vec(input int tag, input vec_t v);
    int nb, nrd, stall_n, nld, nerr;
    logic due, nxt, done, is_ld, is_st;
    logic [31:0] ld_fin;
    logic [31:0] ba[2];
    logic [31:0] bw[2];
    logic [3:0]  bb[2];
    logic        bwe[2];
    i_mem_wren  = v.wren;
    i_data_type = v.dt;
    i_unsigned  = v.uns;
    i_addr      = v.addr;
    i_st_data   = v.st;
    i_bus_rdy   = 1'b1;
    i_bus_rvld  = 1'b0;
    nb = 0; nrd = 0; stall_n = 0; nld = 0; nerr = 0;
    due = 1'b0; nxt = 1'b0; done = 1'b0; ld_fin = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (o_stall) stall_n++;
      if (o_ld_vld) nld++;
      if (o_err) nerr++;
      if (c > 0 && !o_stall) begin
        done   = 1'b1;
        ld_fin = o_ld_data;
      end
      if (o_bus_vld && i_bus_rdy) begin
        if (nb < 2) begin
          ba[nb]  = o_bus_addr;
          bb[nb]  = o_bus_be;
          bw[nb]  = o_bus_wdata;
          bwe[nb] = o_bus_we;
        end
        nb++;
        nxt = !o_bus_we;
      end
      i_bus_rvld  = due;
      i_bus_rdata = (nrd == 0) ? v.r0 : v.r1;
      if (due) nrd++;
      @(posedge i_clk);
      #1;
      due = nxt;
      nxt = 1'b0;
    end
    i_bus_rvld = 1'b0;
    is_ld = (v.wren == 2'b10) && !v.err;
    is_st = (v.wren == 2'b01) && !v.err;
    chk(tag, "done", 32'(done), 32'd1);
    chk(tag, "stall_cycles", stall_n, v.stall);
    chk(tag, "beats", nb, v.nb);
    chk(tag, "ld_vld_pulses", nld, is_ld ? 1 : 0);
    chk(tag, "err_pulses", nerr, v.err ? 1 : 0);
    if (is_ld || v.err) chk(tag, "ld_data", ld_fin, v.ld);
    for (int i = 0; i < 2 && i < nb && i < v.nb; i++) begin
      chk(tag, "beat_addr", ba[i], i == 0 ? v.a0 : v.a1);
      chk(tag, "beat_be", 32'(bb[i]), 32'(i == 0 ? v.be0 : v.be1));
      chk(tag, "beat_we", 32'(bwe[i]), 32'(is_st));
      if (is_st) chk(tag, "beat_wdata", bw[i], i == 0 ? v.w0 : v.w1);
    end
  endtask

  initial begin
    int stall_n;
    vecs[0]  = '{2'b10, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0,
                 3, 1, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0,
                 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{2'b10, 2'b10, 1'b0, 32'h203, 32'h0, 32'h80123456, 32'h0,
                 3, 1, 32'h200, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0,
                 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{2'b10, 2'b10, 1'b1, 32'h203, 32'h0, 32'h80123456, 32'h0,
                 3, 1, 32'h200, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0,
                 32'h00000080, 1'b0};
    vecs[3]  = '{2'b01, 2'b00, 1'b0, 32'h101, 32'h11223344, 32'h0, 32'h0,
                 3, 2, 32'h100, 4'hE, 32'h22334400, 32'h104, 4'h1,
                 32'h00000011, 32'h0, 1'b0};
    vecs[4]  = '{2'b10, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 32'hAB000000,
                 32'h000000CD, 5, 2, 32'hFFFFFFFC, 4'h8, 32'h0, 32'h0, 4'h1,
                 32'h0, 32'hFFFFCDAB, 1'b0};
    vecs[5]  = '{2'b10, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0,
                 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0,
                 32'h0, 1'b1};
    vecs[6]  = '{2'b11, 2'b00, 1'b0, 32'h104, 32'h0, 32'h0, 32'h0,
                 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0,
                 32'h0, 1'b1};
    vecs[7]  = '{2'b01, 2'b01, 1'b0, 32'h202, 32'hAAAA5678, 32'h0, 32'h0,
                 2, 1, 32'h200, 4'hC, 32'h56780000, 32'h0, 4'h0, 32'h0,
                 32'h0, 1'b0};
    vecs[8]  = '{2'b01, 2'b10, 1'b0, 32'h301, 32'h000000EE, 32'h0, 32'h0,
                 2, 1, 32'h300, 4'h2, 32'h0000EE00, 32'h0, 4'h0, 32'h0,
                 32'h0, 1'b0};
    vecs[9]  = '{2'b10, 2'b01, 1'b1, 32'h401, 32'h0, 32'h00F00D00, 32'h0,
                 3, 1, 32'h400, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0,
                 32'h0000F00D, 1'b0};
    vecs[10] = '{2'b10, 2'b00, 1'b0, 32'h502, 32'h0, 32'h55661234,
                 32'h9999AABB, 5, 2, 32'h500, 4'hC, 32'h0, 32'h504, 4'h3,
                 32'h0, 32'hAABB5566, 1'b0};
    vecs[11] = '{2'b01, 2'b00, 1'b0, 32'h603, 32'hA1B2C3D4, 32'h0, 32'h0,
                 3, 2, 32'h600, 4'h8, 32'hD4000000, 32'h604, 4'h7,
                 32'h00A1B2C3, 32'h0, 1'b0};
    vecs[12] = '{2'b10, 2'b01, 1'b0, 32'h702, 32'h0, 32'h80010000, 32'h0,
                 3, 1, 32'h700, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0,
                 32'hFFFF8001, 1'b0};

    i_reset = 1'b1; i_mem_wren = 2'b00; i_data_type = 2'b00;
    i_unsigned = 1'b0; i_addr = '0; i_st_data = '0;
    i_bus_rdy = 1'b0; i_bus_rvld = 1'b0; i_bus_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk(0, "rst_vld", 32'(o_bus_vld), 32'd0);
    chk(0, "rst_we", 32'(o_bus_we), 32'd0);
    chk(0, "rst_addr", o_bus_addr, 32'd0);
    chk(0, "rst_be", 32'(o_bus_be), 32'd0);
    chk(0, "rst_wdata", o_bus_wdata, 32'd0);
    chk(0, "rst_ld_vld", 32'(o_ld_vld), 32'd0);
    chk(0, "rst_ld_data", o_ld_data, 32'd0);
    chk(0, "rst_err", 32'(o_err), 32'd0);
    chk(0, "rst_stall", 32'(o_stall), 32'd0);

    // Vectors run back to back: each new request lands the cycle after DONE.
    for (int n = 0; n < NV; n++) run_vec(n + 1, vecs[n]);
    i_mem_wren = 2'b00;
    @(posedge i_clk);
    #1;

    i_mem_wren = 2'b01; i_data_type = 2'b00; i_addr = 32'h800;
    i_st_data = 32'hCAFEF00D; i_bus_rdy = 1'b0;
    stall_n = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (o_stall) stall_n++;
      if (c >= 1 && c <= 4) begin
        chk(100 + c, "bp_vld", 32'(o_bus_vld), 32'd1);
        chk(100 + c, "bp_addr", o_bus_addr, 32'h800);
        chk(100 + c, "bp_wdata", o_bus_wdata, 32'hCAFEF00D);
        chk(100 + c, "bp_be", 32'(o_bus_be), 32'hF);
      end
      if (c == 5) begin
        chk(105, "bp_done_vld", 32'(o_bus_vld), 32'd0);
        i_mem_wren = 2'b00;
      end
      i_bus_rdy = (c >= 4);
      @(posedge i_clk);
      #1;
    end
    chk(110, "bp_stall_cycles", stall_n, 5);

    i_mem_wren = 2'b10; i_data_type = 2'b00; i_addr = 32'h900;
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b0;
    repeat (2) begin
      #1;
      @(posedge i_clk);
      #1;
    end
    #1;
    chk(120, "resp0_stall", 32'(o_stall), 32'd1);
    chk(120, "resp0_vld", 32'(o_bus_vld), 32'd0);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0; i_mem_wren = 2'b00;
    i_bus_rvld = 1'b1; i_bus_rdata = 32'h12345678;
    #1;
    chk(121, "mrst_vld", 32'(o_bus_vld), 32'd0);
    chk(121, "mrst_addr", o_bus_addr, 32'd0);
    chk(121, "mrst_be", 32'(o_bus_be), 32'd0);
    chk(121, "mrst_wdata", o_bus_wdata, 32'd0);
    chk(121, "mrst_ld_data", o_ld_data, 32'd0);
    chk(121, "mrst_ld_vld", 32'(o_ld_vld), 32'd0);
    chk(121, "mrst_stall", 32'(o_stall), 32'd0);
    @(posedge i_clk);
    #1;
    i_bus_rvld = 1'b0;
    #1;
    chk(122, "late_rvld_ld_vld", 32'(o_ld_vld), 32'd0);
    chk(122, "late_rvld_stall", 32'(o_stall), 32'd0);
    chk(122, "late_rvld_vld", 32'(o_bus_vld), 32'd0);
    run_vec(123, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer sitting between the decode stage and the data-memory bus. It consumes the memory-side control fields the decoder produces (`mem_wren`, data type, unsigned flag) together with the ALU-computed address and the store operand. It drives a word-wide, byte-enabled memory bus with a valid/ready handshake and splits misaligned halfword/word accesses into two bus beats. It stalls the core until the access completes, then returns sign- or zero-extended load data.

## Interface
No parameters. Address and data widths are fixed at 32 bits.

- `i_clk` in 1: sole clock; rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_mem_wren` in 2: operation.
  - 2'b10 = load.
  - 2'b01 = store.
  - 2'b00 = none.
  - 2'b11 = illegal.
- `i_data_type` in 2: access size.
  - 2'b00 = word.
  - 2'b01 = half.
  - 2'b10 = byte.
  - 2'b11 = illegal.
- `i_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `i_addr` in 32: byte address.
- `i_st_data` in 32: store operand; low bytes are used for byte and half stores.
- `o_stall` out 1: core must hold all `i_*` request inputs stable while high.
- `o_ld_vld` out 1: one-cycle pulse; `o_ld_data` is valid in that cycle.
- `o_ld_data` out 32: extended load result.
- `o_err` out 1: one-cycle pulse for an illegal request.
- `o_bus_vld` out 1: bus request valid.
- `i_bus_rdy` in 1: bus accepts the request when `o_bus_vld && i_bus_rdy`.
- `o_bus_we` out 1: 1 = write.
- `o_bus_addr` out 32: word-aligned address; bits [1:0] are always 0.
- `o_bus_be` out 4: byte-lane enables, driven for reads and writes.
- `o_bus_wdata` out 32: lane-aligned write data.
- `i_bus_rvld` in 1: read data returns ≥1 cycle after acceptance; at most one read is outstanding.
- `i_bus_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ0, RESP0, REQ1, RESP1, DONE.
- IDLE:
  - `i_mem_wren` of 2'b10 or 2'b01 with a legal type: capture the request, go to REQ0.
  - Any illegal code: go to DONE with an error flag set.
  - 2'b00: stay in IDLE.
- REQ0 and REQ1: hold `o_bus_vld` high until accepted.
  - On acceptance, a write goes to REQ1 (if split) or DONE.
  - On acceptance, a read goes to RESP0 (from REQ0) or RESP1 (from REQ1).
- RESP0 and RESP1: wait for `i_bus_rvld` and latch `i_bus_rdata`; a split access then goes to REQ1, otherwise to DONE.
- DONE: lasts one cycle, always returns to IDLE, and does not sample the request inputs.
- Outputs in DONE:
  - `o_ld_vld` = 1 for a completed load.
  - `o_err` = 1 for an illegal request.
- `o_stall` = (IDLE && `i_mem_wren` != 0) || (state ∉ {IDLE, DONE}). This term is combinational.
- Let off = `i_addr`[1:0]. A split occurs when (half && off == 3) or (word && off != 0).
- Byte enables:
  - Byte at offset k: 1<<k.
  - Half at off 0 / 1 / 2: 0011 / 0110 / 1100.
  - Half at off 3: 1000, then 0001.
  - Word at off 0: 1111.
  - Word at off 1 / 2 / 3: 1110+0001 / 1100+0011 / 1000+0111.
- Addresses:
  - Beat0 address = `i_addr` & ~3.
  - Beat1 address = beat0 + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Write data:
  - Beat0 = st_data << 8·off.
  - Beat1 = st_data >> 8·(4−off).
- Load assembly:
  - raw = (rdata0 >> 8·off) | (rdata1 << 8·(4−off)); the second term is present only when split.
  - Take raw[7:0], raw[15:0] or raw[31:0] according to size.
  - Extend with sign or zero according to `i_unsigned`.
- Illegal request: no bus activity; `o_ld_data` = 0.

## Timing
- Reset (any state, including mid-transaction):
  - state ← IDLE.
  - `o_bus_vld`, `o_bus_we`, `o_ld_vld` and `o_err` = 0.
  - `o_bus_addr`, `o_bus_be`, `o_bus_wdata` and `o_ld_data` = 0.
  - Any in-flight access is abandoned.
  - An `i_bus_rvld` arriving while in IDLE is ignored.
- `o_bus_*` outputs are registered and remain stable while `o_bus_vld` is high and not yet accepted.
- With `i_bus_rdy` = 1 and rvld one cycle after acceptance:
  - Aligned store: stall high 2 cycles.
  - Aligned load: stall high 3 cycles; `o_ld_vld` in the 4th cycle (DONE).
  - Split store: stall high 3 cycles.
  - Split load: stall high 5 cycles.
  - Illegal request: stall high 1 cycle; `o_err` in the next cycle.
- Back-to-back requests: a new request is sampled in the cycle after DONE, with no bubble beyond DONE.
- Each cycle `i_bus_rdy` stays low extends the stall by one cycle; each cycle of rvld delay extends it by one cycle.

## Test plan
- Aligned word load: addr 0x100, rdata 0xDEADBEEF, rdy = 1 → be 1111, addr 0x100, `o_ld_data` 0xDEADBEEF with `o_ld_vld` in cycle 4.
- Signed vs unsigned byte load: addr 0x203, rdata 0x80xxxxxx → be 1000, `o_ld_data` 0xFFFFFF80 (signed) or 0x00000080 (unsigned).
- Split word store: addr 0x101, st_data 0x11223344 → beat0 addr 0x100, be 1110, wdata 0x22334400; beat1 addr 0x104, be 0001, wdata 0x00000011.
- Split half load with wrap: addr 0xFFFFFFFF, rdata0 0xAB000000, rdata1 0x000000CD, signed → beat1 addr 0x00000000, `o_ld_data` 0xFFFFCDAB.
- Illegal and backpressure cases:
  - Type 2'b11 → `o_err` pulse, no `o_bus_vld`.
  - Aligned store with rdy held low 3 cycles → `o_bus_vld`, addr and wdata held; stall 5 cycles.
- Reset in RESP0, then a late rvld → outputs 0, FSM in IDLE, no `o_ld_vld`; the next request completes normally.
